// File: rtl/prog_loader.sv
// prog_loader: boot-time program loader for the instruction memory.
//
// Listens to the uart_rx byte stream. A SYNC_BYTE opens a session, the next
// four bytes give the word count N (little-endian), and each following group
// of four bytes is one big-endian instruction. Instructions are written to
// consecutive addresses from 0. After the N-th word the loader parks in DONE
// and raises load_done until reset.
//
// Ports
//   clk        system clock (posedge)
//   rst        asynchronous active-high reset
//   rdata      received byte, valid with rx_ready
//   rx_ready   single-cycle strobe for rdata
//   ferr       framing error flag, sampled with rx_ready
//   imem_we    one-cycle instruction-memory write strobe
//   imem_addr  instruction-memory write address
//   imem_din   instruction word to write
//   load_done  load finished (held until reset)
//   err        sticky: framing error or word count beyond memory depth
//   checksum   XOR of every byte accepted as instruction data
module prog_loader #(
  parameter int          INST_SIZE = 10,
  parameter logic [7:0]  SYNC_BYTE = 8'hAA
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [7:0]           rdata,
  input  logic                 rx_ready,
  input  logic                 ferr,
  output logic                 imem_we,
  output logic [INST_SIZE-1:0] imem_addr,
  output logic [31:0]          imem_din,
  output logic                 load_done,
  output logic                 err,
  output logic [7:0]           checksum
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LEN,
    S_DATA,
    S_DONE
  } state_t;

  state_t      state;
  logic [1:0]  byte_cnt;
  logic [31:0] word_idx;
  logic        inc_p0;     // address advance is due one cycle after a word

  // Byte assembly registers carry no control meaning and need no reset:
  // a fresh session always refills them before they are used.
  logic [23:0] len_sr;
  logic [23:0] data_sr;
  logic [31:0] word_cnt;

  logic [31:0] len_word;
  logic [31:0] data_word;
  logic        word_fits;
  logic        last_word;

  assign len_word  = {rdata, len_sr};   // first length byte lands in bits 7:0
  assign data_word = {data_sr, rdata};  // first data byte lands in bits 31:24
  // Indices at or beyond the memory depth are consumed but never written.
  assign word_fits = (word_idx >> INST_SIZE) == 32'd0;
  assign last_word = (word_idx == word_cnt - 32'd1);

  always_ff @(posedge clk) begin
    if (rx_ready) begin
      if (state == S_LEN) begin
        len_sr <= {rdata, len_sr[23:8]};
        if (byte_cnt == 2'd3)
          word_cnt <= len_word;
      end
      if (state == S_DATA)
        data_sr <= {data_sr[15:0], rdata};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      byte_cnt  <= 2'd0;
      word_idx  <= 32'd0;
      inc_p0    <= 1'b0;
      imem_we   <= 1'b0;
      imem_addr <= '0;
      imem_din  <= 32'd0;
      load_done <= 1'b0;
      err       <= 1'b0;
      checksum  <= 8'd0;
    end else begin
      imem_we <= 1'b0;
      inc_p0  <= 1'b0;

      // Address moves on only after the write cycle, so addr/din stay
      // aligned with the write strobe.
      if (inc_p0)
        imem_addr <= imem_addr + INST_SIZE'(1);

      // DONE is entered on the terminating byte's edge; load_done follows
      // one cycle later.
      if (state == S_DONE)
        load_done <= 1'b1;

      if (rx_ready && state != S_DONE) begin
        if (ferr)
          err <= 1'b1;

        case (state)
          S_IDLE: begin
            if (rdata == SYNC_BYTE) begin
              state    <= S_LEN;
              byte_cnt <= 2'd0;
            end
          end

          S_LEN: begin
            byte_cnt <= byte_cnt + 2'd1;
            if (byte_cnt == 2'd3) begin
              if (len_word == 32'd0) begin
                state <= S_DONE;
              end else begin
                state     <= S_DATA;
                imem_addr <= '0;
                word_idx  <= 32'd0;
              end
            end
          end

          S_DATA: begin
            checksum <= checksum ^ rdata;
            byte_cnt <= byte_cnt + 2'd1;
            if (byte_cnt == 2'd3) begin
              inc_p0   <= 1'b1;
              word_idx <= word_idx + 32'd1;
              if (word_fits) begin
                imem_we  <= 1'b1;
                imem_din <= data_word;
              end else begin
                err <= 1'b1;
              end
              if (last_word)
                state <= S_DONE;
            end
          end

          default: state <= state;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_prog_loader.sv
module tb_prog_loader;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] rdata = 8'd0;
  logic       rx_ready = 1'b0;
  logic       ferr = 1'b0;

  logic        we_a, done_a, err_a;
  logic [9:0]  addr_a;
  logic [31:0] din_a;
  logic [7:0]  cks_a;

  logic        we_b, done_b, err_b;
  logic [0:0]  addr_b;
  logic [31:0] din_b;
  logic [7:0]  cks_b;

  always #5 clk = ~clk;

  prog_loader #(.INST_SIZE(10), .SYNC_BYTE(8'hAA)) u_a (
    .clk(clk), .rst(rst), .rdata(rdata), .rx_ready(rx_ready), .ferr(ferr),
    .imem_we(we_a), .imem_addr(addr_a), .imem_din(din_a),
    .load_done(done_a), .err(err_a), .checksum(cks_a)
  );

  prog_loader #(.INST_SIZE(1), .SYNC_BYTE(8'hAA)) u_b (
    .clk(clk), .rst(rst), .rdata(rdata), .rx_ready(rx_ready), .ferr(ferr),
    .imem_we(we_b), .imem_addr(addr_b), .imem_din(din_b),
    .load_done(done_b), .err(err_b), .checksum(cks_b)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- reference model (index 0: depth 1024, index 1: depth 2)
  // The session is tracked as a byte position after the sync byte:
  // positions 1..4 are the count, position p>4 is data byte (p-5).
  int          dep [2] = '{1024, 2};
  bit          m_sync [2];
  int          m_pos  [2];
  logic [31:0] m_n    [2];
  logic [31:0] m_w    [2];
  logic [7:0]  m_cks  [2];
  bit          m_err  [2];
  bit          m_fin  [2];
  int          m_wc   [2];   // words fully received
  bit          e_we   [2];
  int          e_addr [2];
  logic [31:0] e_din  [2];
  bit          e_done [2];
  int          di, k;

  always @(posedge clk or posedge rst) begin
    for (int d = 0; d < 2; d++) begin
      if (rst) begin
        m_sync[d] = 0; m_pos[d] = 0; m_n[d] = 0; m_w[d] = 0; m_cks[d] = 0;
        m_err[d] = 0; m_fin[d] = 0; m_wc[d] = 0;
        e_we[d] = 0; e_addr[d] = 0; e_din[d] = 0; e_done[d] = 0;
      end else begin
        // address and done show the state one edge behind
        e_addr[d] = m_wc[d] % dep[d];
        e_done[d] = m_fin[d];
        e_we[d]   = 0;
        if (rx_ready && !m_fin[d]) begin
          if (ferr) m_err[d] = 1;
          if (!m_sync[d]) begin
            if (rdata == 8'hAA) begin
              m_sync[d] = 1; m_pos[d] = 0; m_n[d] = 0;
            end
          end else begin
            m_pos[d]++;
            if (m_pos[d] <= 4) begin
              m_n[d][8*(m_pos[d]-1) +: 8] = rdata;
              if (m_pos[d] == 4 && m_n[d] == 0) m_fin[d] = 1;
            end else begin
              di = m_pos[d] - 5;
              m_cks[d] = m_cks[d] ^ rdata;
              m_w[d] = {m_w[d][23:0], rdata};
              if (di % 4 == 3) begin
                k = di / 4;
                if (k < dep[d]) begin
                  e_we[d] = 1;
                  e_din[d] = m_w[d];
                end else begin
                  m_err[d] = 1;
                end
                m_wc[d] = k + 1;
                if (longint'(k) == longint'(m_n[d]) - 1) m_fin[d] = 1;
              end
            end
          end
        end
      end
    end
  end

  // ---------------- per-cycle compare
  always @(negedge clk) begin
    chk("a.we",   we_a,   e_we[0]);
    chk("a.addr", addr_a, e_addr[0]);
    chk("a.din",  din_a,  e_din[0]);
    chk("a.done", done_a, e_done[0]);
    chk("a.err",  err_a,  m_err[0]);
    chk("a.cks",  cks_a,  m_cks[0]);
    chk("b.we",   we_b,   e_we[1]);
    chk("b.addr", addr_b, e_addr[1]);
    chk("b.din",  din_b,  e_din[1]);
    chk("b.done", done_b, e_done[1]);
    chk("b.err",  err_b,  m_err[1]);
    chk("b.cks",  cks_b,  m_cks[1]);
  end

  // ---------------- write capture for literal checks
  logic [63:0] wq_a[$];
  logic [63:0] wq_b[$];
  always @(negedge clk) begin
    if (we_a) wq_a.push_back({32'(addr_a), din_a});
    if (we_b) wq_b.push_back({32'(addr_b), din_b});
  end

  task automatic send(input logic [7:0] b, input bit fe, input int gap);
    rdata = b; ferr = fe; rx_ready = 1'b1;
    @(negedge clk);
    rx_ready = 1'b0; ferr = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, ".rst.we"},   we_a,   0);
    chk({tag, ".rst.addr"}, addr_a, 0);
    chk({tag, ".rst.din"},  din_a,  0);
    chk({tag, ".rst.done"}, done_a, 0);
    chk({tag, ".rst.err"},  err_a,  0);
    chk({tag, ".rst.cks"},  cks_a,  0);
    chk({tag, ".rst.cksb"}, cks_b,  0);
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk);
    #2 rst = 1'b1;
    #1 chk_zero(tag);
    @(negedge clk);
    rst = 1'b0;
    wq_a.delete();
    wq_b.delete();
  endtask

  logic [7:0] s_n2 [13] = '{8'hAA, 8'h02, 8'h00, 8'h00, 8'h00,
                            8'h12, 8'h34, 8'h56, 8'h78,
                            8'h9A, 8'hBC, 8'hDE, 8'hF0};
  logic [7:0] s_ov [17] = '{8'hAA, 8'h03, 8'h00, 8'h00, 8'h00,
                            8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66,
                            8'h77, 8'h88, 8'h99, 8'hAA, 8'hBB, 8'hCC};

  initial begin
    #1 chk_zero("init");
    @(negedge clk);
    rst = 1'b0;

    // Sync filter: junk is ignored, a count with no data never writes
    send(8'h55, 0, 1); send(8'h00, 0, 1);
    send(8'hAA, 0, 1); send(8'h04, 0, 1);
    send(8'h00, 0, 1); send(8'h00, 0, 1); send(8'h00, 0, 1);
    repeat (5) @(negedge clk);
    chk("filter.nwr", wq_a.size(), 0);
    chk("filter.done", done_a, 0);

    // Normal load N=2 with gaps, timing pinned around each word end
    do_reset("n2");
    for (int i = 0; i < 13; i++) begin
      send(s_n2[i], 0, (i == 8 || i == 12) ? 0 : 2);
      if (i == 8) begin
        chk("n2.w0.we", we_a, 1);
        chk("n2.w0.addr", addr_a, 0);
        chk("n2.w0.din", din_a, 32'h12345678);
        chk("n2.w0.cks", cks_a, 8'h08);
        @(negedge clk);
        chk("n2.w0.addr+", addr_a, 1);
        chk("n2.w0.we-", we_a, 0);
      end
    end
    chk("n2.w1.we", we_a, 1);
    chk("n2.w1.addr", addr_a, 1);
    chk("n2.w1.din", din_a, 32'h9ABCDEF0);
    chk("n2.done.t1", done_a, 0);
    @(negedge clk);
    chk("n2.done.t2", done_a, 1);
    chk("n2.addr.t2", addr_a, 2);
    chk("n2.cks", cks_a, 8'h00);
    chk("n2.err", err_a, 0);

    // Back-to-back strobes
    do_reset("b2b");
    for (int i = 0; i < 13; i++) send(s_n2[i], 0, 0);
    repeat (3) @(negedge clk);
    chk("b2b.n", wq_a.size(), 2);
    if (wq_a.size() == 2) begin
      chk("b2b.w0", wq_a[0], {32'd0, 32'h12345678});
      chk("b2b.w1", wq_a[1], {32'd1, 32'h9ABCDEF0});
    end
    chk("b2b.done", done_a, 1);

    // N=0 finishes on the last count byte; trailing bytes are ignored
    do_reset("n0");
    send(8'hAA, 0, 1); send(8'h00, 0, 0); send(8'h00, 0, 0);
    send(8'h00, 0, 0); send(8'h00, 0, 0);
    chk("n0.done.t1", done_a, 0);
    @(negedge clk);
    chk("n0.done.t2", done_a, 1);
    send(8'hFF, 0, 2);
    chk("n0.nwr", wq_a.size(), 0);
    chk("n0.cks", cks_a, 0);
    chk("n0.done.hold", done_a, 1);

    // Overflow: the depth-2 instance drops the third word and flags err
    do_reset("ov");
    for (int i = 0; i < 17; i++) send(s_ov[i], 0, 1);
    repeat (3) @(negedge clk);
    chk("ov.b.n", wq_b.size(), 2);
    if (wq_b.size() == 2) begin
      chk("ov.b.w0", wq_b[0], {32'd0, 32'h11223344});
      chk("ov.b.w1", wq_b[1], {32'd1, 32'h55667788});
    end
    chk("ov.b.err", err_b, 1);
    chk("ov.b.done", done_b, 1);
    chk("ov.a.n", wq_a.size(), 3);
    chk("ov.a.err", err_a, 0);

    // Reset mid-DATA, then a fresh load starts at address 0
    do_reset("mid");
    for (int i = 0; i < 7; i++) send(s_n2[i], 0, 0);
    chk("mid.cks.pre", cks_a, 8'h26);
    do_reset("mid2");
    send(8'hAA, 0, 0); send(8'h01, 0, 0); send(8'h00, 0, 0);
    send(8'h00, 0, 0); send(8'h00, 0, 0);
    send(8'hDE, 0, 0); send(8'hAD, 0, 0); send(8'hBE, 0, 0); send(8'hEF, 0, 0);
    repeat (3) @(negedge clk);
    chk("mid.n", wq_a.size(), 1);
    if (wq_a.size() == 1) chk("mid.w0", wq_a[0], {32'd0, 32'hDEADBEEF});
    chk("mid.done", done_a, 1);

    // Randomized sessions against the model
    for (int s = 0; s < 25; s++) begin
      int nj, nw;
      logic [7:0] b;
      do_reset("rnd");
      nj = $urandom_range(0, 3);
      for (int j = 0; j < nj; j++) begin
        do b = 8'($urandom); while (b == 8'hAA);
        send(b, 0, $urandom_range(0, 2));
      end
      send(8'hAA, 0, $urandom_range(0, 2));
      nw = $urandom_range(0, 5);
      for (int j = 0; j < 4; j++)
        send((j == 0) ? 8'(nw) : 8'h00, ($urandom_range(0, 15) == 0), $urandom_range(0, 2));
      for (int j = 0; j < 4 * nw; j++)
        send(8'($urandom), ($urandom_range(0, 15) == 0), $urandom_range(0, 2));
      begin
        int t;
        for (t = 0; t < 10 && !done_a; t++) @(negedge clk);
        chk("rnd.done", done_a, 1);
      end
      for (int j = 0; j < 2; j++) send(8'($urandom), 0, $urandom_range(0, 1));
      chk("rnd.nwr", wq_a.size(), nw);
    end

    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
